// File: rtl/button_conditioner_if.sv
// Push-button conditioner bundle: raw pad input toward the conditioner,
// debounced level and event pulses back out.
interface button_conditioner_if;
    logic button_raw;
    logic button;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output button_raw,
        input  button,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  button_raw,
        output button,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces a mechanical push-button, producing a clean
// level plus one-cycle press, release and long-press pulses.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LCNT_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LCNT_W-1:0]      lcnt_q, lcnt_d;
    logic                   fired_q, fired_d;
    logic                   button_q, button_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.button_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // Next-state: debounce FSM plus hold timer running while the level is high
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lcnt_d    = lcnt_q;
        fired_d   = fired_q;
        button_d  = button_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (button_q) begin
            if (lcnt_q < LCNT_MAX) begin
                lcnt_d = lcnt_q + LCNT_W'(1);
            end else if (!fired_q) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = PRESSED;
                    button_d = 1'b1;
                    press_d  = 1'b1;
                    lcnt_d   = '0;
                    fired_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A return to high is a bounce; the hold timer keeps running
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    button_d  = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                button_d  = 1'b0;
                press_d   = 1'b0;
                release_d = 1'b0;
                long_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            fired_q   <= 1'b0;
            button_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            fired_q   <= fired_d;
            button_q  <= button_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign bus.button        = button_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: default instance plus a
// minimum-debounce / deep-synchroniser / short-long-press instance.
module tb_button_conditioner;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    button_conditioner_if bus_a ();
    button_conditioner_if bus_b ();

    button_conditioner u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    button_conditioner #(
        .SYNC_STAGES       (3),
        .DEBOUNCE_CYCLES   (1),
        .LONG_PRESS_CYCLES (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_a.button_raw = 1'b0;
        bus_b.button_raw = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.button_raw = 1'b1;
        bus_b.button_raw = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_cmp++;
            if ({bus_a.button, bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_a edge %0d: got %b expected 0000", e,
                         {bus_a.button, bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse});
            end
            n_cmp++;
            if ({bus_b.button, bus_b.press_pulse, bus_b.release_pulse, bus_b.long_pulse} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_b edge %0d: got %b expected 0000", e,
                         {bus_b.button, bus_b.press_pulse, bus_b.release_pulse, bus_b.long_pulse});
            end
        end
        reset = 1'b0;
        bus_a.button_raw = 1'b0;
        bus_b.button_raw = 1'b0;
    endtask

    task automatic test_clean_press();
        do_reset();
        for (int e = 0; e < 30; e++) begin
            bus_a.button_raw = (e < 10);
            tick();
            n_cmp++;
            if (bus_a.press_pulse !== (e == 6)) begin
                n_err++;
                $display("FAIL clean_press edge %0d: press_pulse=%b expected %b", e, bus_a.press_pulse, (e == 6));
            end
            n_cmp++;
            if (bus_a.button !== (e >= 6 && e < 16)) begin
                n_err++;
                $display("FAIL clean_button edge %0d: button=%b expected %b", e, bus_a.button, (e >= 6 && e < 16));
            end
            n_cmp++;
            if (bus_a.release_pulse !== (e == 16)) begin
                n_err++;
                $display("FAIL clean_release edge %0d: release_pulse=%b expected %b", e, bus_a.release_pulse, (e == 16));
            end
        end
    endtask

    task automatic test_bounce_press();
        logic [5:0] pat;
        int         presses;
        pat     = 6'b101101;
        presses = 0;
        do_reset();
        for (int e = 0; e < 24; e++) begin
            bus_a.button_raw = (e < 6) ? pat[5 - e] : 1'b1;
            tick();
            if (bus_a.press_pulse === 1'b1) presses++;
            n_cmp++;
            if (bus_a.press_pulse !== (e == 11)) begin
                n_err++;
                $display("FAIL bounce_press edge %0d: press_pulse=%b expected %b", e, bus_a.press_pulse, (e == 11));
            end
            n_cmp++;
            if (bus_a.button !== (e >= 11)) begin
                n_err++;
                $display("FAIL bounce_button edge %0d: button=%b expected %b", e, bus_a.button, (e >= 11));
            end
        end
        n_cmp++;
        if (presses !== 1) begin
            n_err++;
            $display("FAIL bounce_count: press pulses=%0d expected 1", presses);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 0; e < 20; e++) begin
            bus_a.button_raw = (e < 4);
            tick();
            n_cmp++;
            if ({bus_a.button, bus_a.press_pulse, bus_a.release_pulse} !== 3'b000) begin
                n_err++;
                $display("FAIL glitch edge %0d: button/press/release=%b expected 000", e,
                         {bus_a.button, bus_a.press_pulse, bus_a.release_pulse});
            end
        end
    endtask

    task automatic test_long_press();
        int longs;
        longs = 0;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            bus_a.button_raw = 1'b1;
            tick();
            if (bus_a.long_pulse === 1'b1) longs++;
            n_cmp++;
            if (bus_a.long_pulse !== (e == 26)) begin
                n_err++;
                $display("FAIL long_pulse edge %0d: long_pulse=%b expected %b", e, bus_a.long_pulse, (e == 26));
            end
            n_cmp++;
            if (bus_a.press_pulse !== (e == 6)) begin
                n_err++;
                $display("FAIL long_press edge %0d: press_pulse=%b expected %b", e, bus_a.press_pulse, (e == 6));
            end
        end
        n_cmp++;
        if (longs !== 1) begin
            n_err++;
            $display("FAIL long_count: long pulses=%0d expected 1", longs);
        end
    endtask

    task automatic test_long_bounce();
        do_reset();
        for (int e = 0; e < 40; e++) begin
            bus_a.button_raw = !(e >= 12 && e <= 14);
            tick();
            n_cmp++;
            if (bus_a.long_pulse !== (e == 26)) begin
                n_err++;
                $display("FAIL long_bounce_pulse edge %0d: long_pulse=%b expected %b", e, bus_a.long_pulse, (e == 26));
            end
            n_cmp++;
            if (bus_a.button !== (e >= 6)) begin
                n_err++;
                $display("FAIL long_bounce_button edge %0d: button=%b expected %b", e, bus_a.button, (e >= 6));
            end
            n_cmp++;
            if (bus_a.release_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL long_bounce_release edge %0d: release_pulse=%b expected 0", e, bus_a.release_pulse);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int e = 0; e < 26; e++) begin
            bus_a.button_raw = 1'b1;
            reset = (e == 10);
            tick();
            reset = 1'b0;
            n_cmp++;
            if (bus_a.button !== ((e >= 6 && e < 10) || e >= 17)) begin
                n_err++;
                $display("FAIL rst_hold_button edge %0d: button=%b expected %b", e, bus_a.button,
                         ((e >= 6 && e < 10) || e >= 17));
            end
            n_cmp++;
            if (bus_a.press_pulse !== (e == 6 || e == 17)) begin
                n_err++;
                $display("FAIL rst_hold_press edge %0d: press_pulse=%b expected %b", e, bus_a.press_pulse,
                         (e == 6 || e == 17));
            end
            n_cmp++;
            if ({bus_a.release_pulse, bus_a.long_pulse} !== 2'b00) begin
                n_err++;
                $display("FAIL rst_hold_rel_long edge %0d: release/long=%b expected 00", e,
                         {bus_a.release_pulse, bus_a.long_pulse});
            end
        end
    endtask

    task automatic test_short_hold();
        do_reset();
        for (int e = 0; e < 36; e++) begin
            bus_a.button_raw = (e < 12);
            tick();
            n_cmp++;
            if (bus_a.release_pulse !== (e == 18)) begin
                n_err++;
                $display("FAIL short_release edge %0d: release_pulse=%b expected %b", e, bus_a.release_pulse, (e == 18));
            end
            n_cmp++;
            if (bus_a.long_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL short_long edge %0d: long_pulse=%b expected 0", e, bus_a.long_pulse);
            end
            n_cmp++;
            if (bus_a.button !== (e >= 6 && e < 18)) begin
                n_err++;
                $display("FAIL short_button edge %0d: button=%b expected %b", e, bus_a.button, (e >= 6 && e < 18));
            end
        end
    endtask

    task automatic test_min_debounce();
        do_reset();
        for (int e = 0; e < 18; e++) begin
            bus_b.button_raw = (e < 8);
            tick();
            n_cmp++;
            if (bus_b.press_pulse !== (e == 4)) begin
                n_err++;
                $display("FAIL min_press edge %0d: press_pulse=%b expected %b", e, bus_b.press_pulse, (e == 4));
            end
            n_cmp++;
            if (bus_b.button !== (e >= 4 && e < 12)) begin
                n_err++;
                $display("FAIL min_button edge %0d: button=%b expected %b", e, bus_b.button, (e >= 4 && e < 12));
            end
            n_cmp++;
            if (bus_b.long_pulse !== (e == 6)) begin
                n_err++;
                $display("FAIL min_long edge %0d: long_pulse=%b expected %b", e, bus_b.long_pulse, (e == 6));
            end
            n_cmp++;
            if (bus_b.release_pulse !== (e == 12)) begin
                n_err++;
                $display("FAIL min_release edge %0d: release_pulse=%b expected %b", e, bus_b.release_pulse, (e == 12));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_a.button_raw = 1'b0;
        bus_b.button_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_glitch();
        test_long_press();
        test_long_bounce();
        test_reset_mid_hold();
        test_short_hold();
        test_min_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
